// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Brief    : FIFO pointer/occupancy controller for an external register file
//            with a combinational read port; registered pop data.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          err,
    input  logic          err_clr,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_pop_data;
    logic          r_pop_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_err;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_ovf_cond;
    logic w_udf_cond;

    // Flags come from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push_acc = push & ~w_full;
    assign w_pop_acc  = pop & ~w_empty;
    assign w_ovf_cond = push & w_full;
    assign w_udf_cond = pop & w_empty;

    // Gating with rst_n keeps the register file from being written while reset is held.
    assign rf_wr_en   = w_push_acc & rst_n;
    assign rf_wr_addr = r_wr_ptr;
    assign rf_wr_data = push_data;
    assign rf_rd_addr = r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_pop_data <= rf_rd_data;
            end
            r_pop_valid <= w_pop_acc;

            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase

            r_overflow  <= w_ovf_cond;
            r_underflow <= w_udf_cond;

            if (err_clr) begin
                r_err <= 1'b0;
            end else if (w_ovf_cond | w_udf_cond) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Brief    : Directed scoreboard bench for fifo_ctrl with a behavioural
//            register file attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          err;
    logic          err_clr;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;

    logic [DW-1:0] mem [0:7];

    fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .err        (err),
        .err_clr    (err_clr),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    end
    assign rf_rd_data = mem[rf_rd_addr];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb [$];
    int            m_count;
    int            m_wr;
    int            m_rd;
    logic          m_err;
    logic [DW-1:0] m_pop_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count    = 0;
        m_wr       = 0;
        m_rd       = 0;
        m_err      = 1'b0;
        m_pop_data = '0;
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_count"},     count,      0);
        chk({pfx, "_empty"},     empty,      1);
        chk({pfx, "_full"},      full,       0);
        chk({pfx, "_pop_data"},  pop_data,   0);
        chk({pfx, "_pop_valid"}, pop_valid,  0);
        chk({pfx, "_overflow"},  overflow,   0);
        chk({pfx, "_underflow"}, underflow,  0);
        chk({pfx, "_err"},       err,        0);
        chk({pfx, "_wr_addr"},   rf_wr_addr, 0);
        chk({pfx, "_rd_addr"},   rf_rd_addr, 0);
    endtask

    // One clock of stimulus: entered and left at posedge+1.
    task automatic cycle(input logic p, input logic [DW-1:0] d, input logic q, input logic clr);
        logic ovf, udf, ap, aq;
        push      = p;
        push_data = d;
        pop       = q;
        err_clr   = clr;
        ovf = p && (m_count == 8);
        udf = q && (m_count == 0);
        ap  = p && !ovf;
        aq  = q && !udf;
        #1;
        chk("rf_wr_en",   rf_wr_en,   ap);
        chk("rf_wr_addr", rf_wr_addr, m_wr);
        chk("rf_rd_addr", rf_rd_addr, m_rd);
        if (ap) chk("rf_wr_data", rf_wr_data, d);
        if (aq) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                m_pop_data = sb.pop_front();
            end
            m_rd = (m_rd + 1) % 8;
        end
        if (ap) begin
            sb.push_back(d);
            m_wr = (m_wr + 1) % 8;
        end
        m_count = m_count + (ap ? 1 : 0) - (aq ? 1 : 0);
        m_err   = clr ? 1'b0 : (m_err | ovf | udf);
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        chk("pop_valid", pop_valid, aq);
        chk("pop_data",  pop_data,  m_pop_data);
        chk("overflow",  overflow,  ovf);
        chk("underflow", underflow, udf);
        chk("count",     count,     m_count);
        chk("full",      full,      m_count == 8);
        chk("empty",     empty,     m_count == 0);
        chk("err",       err,       m_err);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_count > 0 && guard < 40) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_bound", m_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        err_clr   = 1'b0;
        model_reset();

        // Reset state, including the write strobe being held off during reset.
        push = 1'b1;
        #12;
        chk("rst_wr_en", rf_wr_en, 0);
        push = 1'b0;
        chk_reset_values("rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ordering.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("order_0", pop_data, 8'h11);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("order_1", pop_data, 8'h22);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("order_2", pop_data, 8'h33);
        chk("order_empty", empty, 1);

        // Fill to full, then an overflowing push.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        chk("fill_full",  full,  1);
        chk("fill_count", count, 8);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_err",   err,      1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_one_cycle", overflow, 0);

        // Push and pop together while full: only the pop is taken.
        cycle(1'b1, 8'hEF, 1'b1, 1'b0);
        chk("fullpp_data", pop_data, 8'hA0);
        chk("fullpp_cnt",  count,    7);
        chk("fullpp_ovf",  overflow, 1);
        drain();

        // Underflow, then push and pop together while empty.
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("udf_pulse", underflow, 1);
        chk("udf_valid", pop_valid, 0);
        cycle(1'b1, 8'h5C, 1'b1, 1'b0);
        chk("emptypp_cnt", count,     1);
        chk("emptypp_udf", underflow, 1);

        // Clear beats a simultaneous set.
        drain();
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("clr_wins", err, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Interleaved stream across several pointer wraps.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h30 + 8'(i * 7), (i % 3) != 0, 1'b0);
        drain();
        chk("stream_left", sb.size(), 0);

        // Asynchronous reset in the middle of a burst.
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_err",   err,   1);
        push      = 1'b1;
        push_data = 8'hDD;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", rf_wr_en, 0);
        chk_reset_values("arst");
        model_reset();
        push = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_0", pop_data, 8'h5A);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_1", pop_data, 8'h5B);
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
